// File: rtl/fifo_pkg.sv
// Shared helpers for both sides of the asynchronous FIFO: pointer width and
// binary/Gray conversions.
package fifo_pkg;

    localparam int MAX_W = 32;

    function automatic int PTR_W(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
        logic [MAX_W-1:0] bin;
        bin[MAX_W-1] = gray[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus: requests and the synchronised read pointer in, memory
// controls and status flags out.
interface fifo_wr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
);
    localparam int PW = PTR_W(ADDR_WIDTH);

    logic                  winc;
    logic [PW-1:0]         sync_r2w_ptr;
    logic [PW-1:0]         afull_thresh;
    logic                  wovf_clr;
    logic [PW-1:0]         gray_w2r_ptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wen;
    logic                  wfull;
    logic                  wafull;
    logic [PW-1:0]         wlevel;
    logic                  wovf;

    modport master (
        output winc, sync_r2w_ptr, afull_thresh, wovf_clr,
        input  gray_w2r_ptr, waddr, wen, wfull, wafull, wlevel, wovf
    );

    modport slave (
        input  winc, sync_r2w_ptr, afull_thresh, wovf_clr,
        output gray_w2r_ptr, waddr, wen, wfull, wafull, wlevel, wovf
    );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of any width; shared by the read
// and write controllers.
module fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Reduction over the upper slice avoids a self-referencing chain on o_bin.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO controller: binary/Gray write pointers, registered full,
// almost-full and fill level, and a sticky overflow flag.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                 wclk,
    input  logic                 wrst,
    fifo_wr_ctrl_if.slave        bus
);

    localparam int PW = PTR_W(ADDR_WIDTH);

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic [PW-1:0] r_wlevel;
    logic          r_wfull;
    logic          r_wafull;
    logic          r_wovf;

    logic          w_wen;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_full_gray;
    logic [PW-1:0] w_level_next;

    assign w_wen        = bus.winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{(PW-1){1'b0}}, w_wen};
    assign w_wgray_next = PW'(bin2gray(MAX_W'(w_wbin_next)));

    fifo_gray2bin #(
        .WIDTH (PW)
    ) u_sync_g2b (
        .i_gray (bus.sync_r2w_ptr),
        .o_bin  (w_rbin)
    );

    // Full is the read pointer one lap behind: top two Gray bits inverted.
    assign w_full_gray  = {~bus.sync_r2w_ptr[PW-1:PW-2], bus.sync_r2w_ptr[PW-3:0]};
    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge wclk) begin
        // NOTE: state registers use non-blocking assignments so every flag
        // below sees the pre-edge values, independent of statement order.
        if (wrst) begin
            r_wbin   <= '0;
            r_wgray  <= '0;
            r_wlevel <= '0;
            r_wfull  <= 1'b0;
            r_wafull <= 1'b0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wgray  <= w_wgray_next;
            r_wlevel <= w_level_next;
            r_wfull  <= (w_wgray_next == w_full_gray);
            r_wafull <= (w_level_next >= bus.afull_thresh);
            if (bus.winc && r_wfull) begin
                r_wovf <= 1'b1;
            end else if (bus.wovf_clr) begin
                r_wovf <= 1'b0;
            end
        end
    end

    assign bus.gray_w2r_ptr = r_wgray;
    assign bus.waddr        = r_wbin[ADDR_WIDTH-1:0];
    assign bus.wen          = w_wen;
    assign bus.wfull        = r_wfull;
    assign bus.wafull       = r_wafull;
    assign bus.wlevel       = r_wlevel;
    assign bus.wovf         = r_wovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with ADDR_WIDTH=3 (depth 8, 4-bit pointers).
module tb_fifo_wr_ctrl;

    localparam int AW = 3;
    localparam int PW = 4;

    logic wclk = 1'b0;
    logic wrst;

    always #5 wclk = ~wclk;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) tb_if ();

    fifo_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (tb_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] exp_bin;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        tb_if.winc = 1'b1;
        tb_if.sync_r2w_ptr = 4'b0000;
        tb_if.afull_thresh = 4'd6;
        tb_if.wovf_clr = 1'b0;
        tick();
        tick();
        n_checks++;
        if (tb_if.wen !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wen: got %b expected 1", tb_if.wen);
        end
        n_checks++;
        if ({tb_if.gray_w2r_ptr, tb_if.waddr, tb_if.wfull, tb_if.wafull, tb_if.wlevel, tb_if.wovf} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_state: got gray=%b addr=%0d full=%b afull=%b lvl=%0d ovf=%b expected all zero",
                     tb_if.gray_w2r_ptr, tb_if.waddr, tb_if.wfull, tb_if.wafull, tb_if.wlevel, tb_if.wovf);
        end
    endtask

    task automatic test_fill();
        logic [PW-1:0] exp_g [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                     4'b0111, 4'b0101, 4'b0100, 4'b1100};
        wrst = 1'b0;
        tb_if.winc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({tb_if.gray_w2r_ptr, tb_if.wafull, tb_if.wfull} !== {exp_g[i], i >= 5, i == 7}) begin
                n_fail++;
                $display("FAIL fill_%0d: got gray=%b afull=%b full=%b expected gray=%b afull=%b full=%b",
                         i + 1, tb_if.gray_w2r_ptr, tb_if.wafull, tb_if.wfull, exp_g[i], i >= 5, i == 7);
            end
        end
        n_checks++;
        if ({tb_if.wlevel, tb_if.waddr} !== {4'd8, 3'd0}) begin
            n_fail++;
            $display("FAIL fill_level: got lvl=%0d addr=%0d expected lvl=8 addr=0", tb_if.wlevel, tb_if.waddr);
        end
    endtask

    task automatic test_overflow();
        tb_if.winc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({tb_if.wen, tb_if.waddr, tb_if.gray_w2r_ptr, tb_if.wovf} !== {1'b0, 3'd0, 4'b1100, 1'b1}) begin
                n_fail++;
                $display("FAIL ovf_hold_%0d: got wen=%b addr=%0d gray=%b ovf=%b expected wen=0 addr=0 gray=1100 ovf=1",
                         i, tb_if.wen, tb_if.waddr, tb_if.gray_w2r_ptr, tb_if.wovf);
            end
        end
        tb_if.winc = 1'b0;
        tb_if.wovf_clr = 1'b1;
        tick();
        n_checks++;
        if (tb_if.wovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b expected 0", tb_if.wovf);
        end
        tb_if.winc = 1'b1;
        tick();
        n_checks++;
        if ({tb_if.wovf, tb_if.gray_w2r_ptr} !== {1'b1, 4'b1100}) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got ovf=%b gray=%b expected ovf=1 gray=1100", tb_if.wovf, tb_if.gray_w2r_ptr);
        end
        tb_if.winc = 1'b0;
        tb_if.wovf_clr = 1'b0;
    endtask

    task automatic test_drain_refill();
        tb_if.sync_r2w_ptr = 4'b0011;
        tick();
        n_checks++;
        if ({tb_if.wfull, tb_if.wlevel, tb_if.wafull} !== {1'b0, 4'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL drain: got full=%b lvl=%0d afull=%b expected full=0 lvl=6 afull=1",
                     tb_if.wfull, tb_if.wlevel, tb_if.wafull);
        end
        tb_if.winc = 1'b1;
        tick();
        n_checks++;
        if ({tb_if.wfull, tb_if.gray_w2r_ptr, tb_if.wlevel} !== {1'b0, 4'b1101, 4'd7}) begin
            n_fail++;
            $display("FAIL refill_1: got full=%b gray=%b lvl=%0d expected full=0 gray=1101 lvl=7",
                     tb_if.wfull, tb_if.gray_w2r_ptr, tb_if.wlevel);
        end
        tick();
        n_checks++;
        if ({tb_if.wfull, tb_if.gray_w2r_ptr, tb_if.wlevel} !== {1'b1, 4'b1111, 4'd8}) begin
            n_fail++;
            $display("FAIL refill_2: got full=%b gray=%b lvl=%0d expected full=1 gray=1111 lvl=8",
                     tb_if.wfull, tb_if.gray_w2r_ptr, tb_if.wlevel);
        end
        tb_if.winc = 1'b0;
        exp_bin = 4'd10;
    endtask

    task automatic test_wrap();
        logic [PW-1:0] rb;
        tb_if.sync_r2w_ptr = to_gray(exp_bin - 4'd3);
        tick();
        n_checks++;
        if ({tb_if.wlevel, tb_if.wfull} !== {4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_start: got lvl=%0d full=%b expected lvl=3 full=0", tb_if.wlevel, tb_if.wfull);
        end
        tb_if.winc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rb = exp_bin - 4'd2;
            tb_if.sync_r2w_ptr = to_gray(rb);
            tick();
            exp_bin = exp_bin + 4'd1;
            n_checks++;
            if ({tb_if.gray_w2r_ptr, tb_if.wlevel, tb_if.wfull} !== {to_gray(exp_bin), 4'd3, 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_%0d: got gray=%b lvl=%0d full=%b expected gray=%b lvl=3 full=0",
                         i, tb_if.gray_w2r_ptr, tb_if.wlevel, tb_if.wfull, to_gray(exp_bin));
            end
        end
        tb_if.winc = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        // Read pointer parked at bin 11, write pointer at 14: full at bin 3.
        tb_if.winc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if ({tb_if.wfull, tb_if.gray_w2r_ptr} !== {1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL mid_full: got full=%b gray=%b expected full=1 gray=0010", tb_if.wfull, tb_if.gray_w2r_ptr);
        end
        tick();
        tb_if.winc = 1'b0;
        tb_if.sync_r2w_ptr = to_gray(4'd14);
        tick();
        n_checks++;
        if ({tb_if.wlevel, tb_if.wfull, tb_if.wovf} !== {4'd5, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_setup: got lvl=%0d full=%b ovf=%b expected lvl=5 full=0 ovf=1",
                     tb_if.wlevel, tb_if.wfull, tb_if.wovf);
        end
        tb_if.winc = 1'b1;
        wrst = 1'b1;
        tb_if.sync_r2w_ptr = 4'b0000;
        tick();
        n_checks++;
        if ({tb_if.gray_w2r_ptr, tb_if.waddr, tb_if.wfull, tb_if.wafull, tb_if.wlevel, tb_if.wovf} !== 13'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got gray=%b addr=%0d full=%b afull=%b lvl=%0d ovf=%b expected all zero",
                     tb_if.gray_w2r_ptr, tb_if.waddr, tb_if.wfull, tb_if.wafull, tb_if.wlevel, tb_if.wovf);
        end
        wrst = 1'b0;
        n_checks++;
        if ({tb_if.wen, tb_if.waddr} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL resume_addr: got wen=%b addr=%0d expected wen=1 addr=0", tb_if.wen, tb_if.waddr);
        end
        tick();
        n_checks++;
        if ({tb_if.waddr, tb_if.gray_w2r_ptr} !== {3'd1, 4'b0001}) begin
            n_fail++;
            $display("FAIL resume_step: got addr=%0d gray=%b expected addr=1 gray=0001", tb_if.waddr, tb_if.gray_w2r_ptr);
        end
        tb_if.winc = 1'b0;
    endtask

    task automatic test_thresh_bounds();
        tb_if.afull_thresh = 4'd0;
        tick();
        n_checks++;
        if (tb_if.wafull !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh_zero: got afull=%b expected 1", tb_if.wafull);
        end
        tb_if.afull_thresh = 4'd9;
        tb_if.winc = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (tb_if.wafull !== 1'b0) begin
                n_fail++;
                $display("FAIL thresh_high_%0d: got afull=%b expected 0", i, tb_if.wafull);
            end
        end
        n_checks++;
        if ({tb_if.wfull, tb_if.wlevel} !== {1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL thresh_high_full: got full=%b lvl=%0d expected full=1 lvl=8", tb_if.wfull, tb_if.wlevel);
        end
        tb_if.winc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_refill();
        test_wrap();
        test_reset_mid_burst();
        test_thresh_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Parametrised write-side controller for the asynchronous FIFO, the successor to the fixed 4-bit-pointer write block. It keeps the binary and Gray write pointers and drives the memory address and write enable. It produces registered full, programmable almost-full and fill-level outputs from the read pointer, which arrives already synchronised into the write domain. It also flags writes attempted while the FIFO is full.

Parameters:
ADDR_WIDTH, 3, memory address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.

Ports:
wclk  in  1  write-domain clock, all state on rising edge
wrst  in  1  synchronous active-high reset
winc  in  1  write request
sync_r2w_ptr  in  ADDR_WIDTH+1  read Gray pointer, 2-FF synchronised into wclk domain
afull_thresh  in  ADDR_WIDTH+1  almost-full threshold in entries (quasi-static)
wovf_clr  in  1  clears sticky overflow flag
gray_w2r_ptr  out  ADDR_WIDTH+1  registered write Gray pointer, to read-side synchroniser
waddr  out  ADDR_WIDTH  memory write address = binary pointer LSBs
wen  out  1  memory write enable
wfull  out  1  registered full flag
wafull  out  1  registered almost-full flag
wlevel  out  ADDR_WIDTH+1  registered fill level seen from write side (pessimistic)
wovf  out  1  sticky overflow flag

Behaviour:
- Reset: wclk only, synchronous, active-high. While wrst=1 at an edge: wbin, gray_w2r_ptr, wfull, wafull, wlevel, wovf all <= 0; waddr=0. Reset wins over every other input, including mid-burst.
- Accept: wen = winc & ~wfull (combinational; memory writes at the same edge).
- Next state:
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Both registered on the same edge, so gray_w2r_ptr always equals bin2gray(wbin).
  - Exactly one Gray bit changes per accepted write. No lookup table; any ADDR_WIDTH >= 2 must work.
- Full: wfull <= (wgray_next == {~sync_r2w_ptr[MSB:MSB-1], sync_r2w_ptr[MSB-2:0]}).
  - Asserts on the edge that accepts the write filling the last entry, so there is zero-cycle lag to the writer.
  - Deasserts one edge after sync_r2w_ptr advances.
- Level: rbin = gray2bin(sync_r2w_ptr); wlevel <= wbin_next - rbin, modulo 2**(ADDR_WIDTH+1). The range is 0..depth; wlevel = depth exactly when wfull = 1.
- Almost-full: wafull <= ((wbin_next - rbin) >= afull_thresh).
  - afull_thresh = 0 makes wafull permanently 1 out of reset.
  - afull_thresh > depth means wafull never asserts.
- Overflow: if winc & wfull at an edge, wovf <= 1. Otherwise, if wovf_clr, wovf <= 0.
  - A simultaneous overflow and clear leaves wovf = 1 (set wins).
  - The pointer never advances while wfull = 1.
- Wrap-around: the binary pointer rolls from all-ones to 0. The MSB toggle distinguishes full from empty. No special case is needed.
- Read-pointer bounds: a sync_r2w_ptr that is ahead of the write pointer is illegal and the bench need not check it. A stale sync_r2w_ptr only makes the flags pessimistic, never optimistic.

Decomposition:
- Shared package fifo_pkg: functions bin2gray and gray2bin, plus constant helper PTR_W(ADDR_WIDTH) = ADDR_WIDTH+1. The read-side controller reuses the same package.
- One sub-module: fifo_gray2bin, parametrised width, purely combinational XOR-prefix chain. It is instantiated for sync_r2w_ptr and also reused on the read side.

Test Plan:
All scenarios use ADDR_WIDTH=3 (depth 8, 4-bit pointers).
1. Hold wrst=1 for 2 edges with winc=1 -> waddr=0, gray_w2r_ptr=0000, wfull=0, wlevel=0, wovf=0, wen=1 but the pointer does not advance.
2. sync_r2w_ptr=0000, afull_thresh=6, winc=1 for 8 edges:
   - gray_w2r_ptr steps 0001,0011,0010,0110,0111,0101,0100,1100.
   - wafull rises on the 6th edge; wfull=1 and wlevel=8 after the 8th edge.
3. Continue winc=1 for 2 edges while full -> wen=0, waddr stays 0, gray holds 1100, wovf=1. Then wovf_clr=1 with winc=0 -> wovf=0. Then wovf_clr=1 with winc=1 while full -> wovf stays 1.
4. From full, set sync_r2w_ptr=0011 (read bin 2) -> one edge later wfull=0, wlevel=6, wafull=1. Two more writes -> wfull=1 with gray 1111.
5. Run 20 writes with sync_r2w_ptr tracking (write ptr - 3) -> binary wraps 1111->0000, gray 1000->0000, wfull never asserts, wlevel constant at 3.
6. Assert wrst for one edge mid-burst at level 5 with wovf=1 -> every output returns to its reset value on that edge. Writes resume at waddr=0 next edge.
